rs485_tx_scheduler: RTL and testbench
=====================================

# rs485_tx_scheduler

Sequences the RS485 transmit path. It pops 16-bit words from the TX FIFO, loads them into the transmitter, and starts each transmission. It also owns the half-duplex driver-enable, with lead and tail guard times and back-to-back bursting, and aborts hung transmissions on timeout. It sits between the APB-facing FIFO and the transmitter/detector block.

## Interface
Parameters:
- DATA_W, 16, word width of FIFO and transmitter
- LEAD_CYC, 4, cycles drv_en is high before first tx_start of a burst (≥1)
- TAIL_CYC, 4, cycles drv_en stays high after last completion (≥1)
- TIMEOUT_CYC, 1024, max cycles from tx_start to tx_complete (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (PCLK domain)
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduler enable (APB control register)
- rx_busy  in  1  line currently receiving; blocks bus acquisition
- fifo_empty  in  1  TX FIFO empty
- fifo_rd  out  1  single-cycle pop strobe
- fifo_data  in  DATA_W  FIFO head; valid the cycle after fifo_rd
- tx_byte  out  DATA_W  word presented to transmitter
- tx_start  out  1  single-cycle start pulse
- tx_complete  in  1  single-cycle completion pulse from transmitter
- drv_en  out  1  RS485 driver enable (DE)
- timeout_err  out  1  single-cycle pulse on aborted transmission
- sent_count  out  8  completed words, wraps 255→0
- idle  out  1  high in IDLE

## Operation
- States: IDLE, POP, LOAD, LEAD, SEND, TAIL. A burst flag marks that the current word was popped while drv_en was already high.
- IDLE: go to POP when enable && !fifo_empty && !rx_busy. Clear burst.
- POP: fifo_rd=1 for exactly one cycle, then go to LOAD.
- LOAD: register fifo_data into tx_byte. Go to SEND if burst, else to LEAD.
- LEAD: hold for LEAD_CYC cycles, then go to SEND.
- SEND: tx_start=1 on the first SEND cycle only. tx_complete on that same cycle is ignored. On tx_complete:
  - increment sent_count;
  - if enable && !fifo_empty (sampled in that cycle), set burst and go to POP;
  - otherwise go to TAIL.
- SEND timeout: if TIMEOUT_CYC cycles elapse from the tx_start cycle with no completion, pulse timeout_err, do not increment sent_count, and go to TAIL.
- TAIL: hold for TAIL_CYC cycles, then go to IDLE. No pops in TAIL.
- drv_en=1 in LEAD, SEND and TAIL, and in POP/LOAD when burst=1. Otherwise 0.
- enable deassert mid-word: the current word completes (or times out), then TAIL. It never drops the word or drv_en early.
- rx_busy is checked only in IDLE.
- fifo_rd is never asserted while fifo_empty=1.

## Timing
- Reset values:
  - state=IDLE, burst=0
  - fifo_rd=0, tx_start=0, drv_en=0, timeout_err=0
  - tx_byte=0, sent_count=0, idle=1
- Latency from first burst word:
  - IDLE condition true in cycle N: fifo_rd in N+1, tx_byte valid from N+3.
  - drv_en rises at N+3.
  - tx_start at N+3+LEAD_CYC.
- Burst word: tx_complete in cycle M gives fifo_rd at M+1, tx_start at M+3. drv_en stays continuously high.
- After the last tx_complete at cycle M: drv_en falls at M+1+TAIL_CYC, and idle=1 from the same cycle.
- Reset asserted mid-operation: next cycle is IDLE with all outputs at reset values. A popped word not yet sent is lost (documented).
- sent_count is modulo 256.

## Structure
- Package rs485_pkg: state enum, DATA_W default, sent_count width, parameter range checks.
- Sub-module rs485_cycle_timer: loadable down-counter with a zero flag. One instance is shared for LEAD, TAIL and TIMEOUT, sized for max(LEAD_CYC, TAIL_CYC, TIMEOUT_CYC).

## Test plan
- Single word: FIFO holds 16'hA55A, enable=1, LEAD=4. Expect fifo_rd at N+1, tx_byte=16'hA55A, tx_start at N+7. tx_complete 50 cycles later gives sent_count=1, drv_en low TAIL_CYC+1 cycles after completion.
- Burst of 3 words (16'h0001, 16'h0002, 16'h0003): drv_en is never low between words, exactly one LEAD, each tx_start follows its tx_complete by 3 cycles, final sent_count=3.
- rx_busy=1 with a non-empty FIFO for 20 cycles: no fifo_rd, drv_en=0. rx_busy falls, then the normal sequence runs from the next cycle.
- Timeout with TIMEOUT_CYC=16 and tx_complete never sent: timeout_err pulses once 16 cycles after tx_start, sent_count unchanged, TAIL then IDLE.
- enable dropped during SEND of word 1 of 2: word 1 completes, then TAIL. Word 2 stays in the FIFO and is not popped.
- Reset in LEAD: next cycle all outputs at reset values, idle=1. sent_count wraps 255→0 on the 256th completion.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 transmit scheduler.
// The helper functions derive the shared timer width and check parameter ranges.
package rs485_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SENT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_LEAD,
    ST_SEND,
    ST_TAIL
  } rs485_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Widest value the shared timer must hold; the timeout load is TIMEOUT_CYC itself.
  function automatic int timer_w(input int lead, input int tail, input int tmo);
    return $clog2(max3(lead, tail, tmo) + 1);
  endfunction

  function automatic bit cfg_ok(input int dw, input int lead, input int tail, input int tmo);
    return (dw >= 1) && (lead >= 1) && (tail >= 1) && (tmo >= 2);
  endfunction

endpackage

// File: rtl/rs485_cycle_timer.sv
// Loadable down-counter with a zero flag; shared by the lead, tail and
// transmit-timeout phases of the scheduler.
module rs485_cycle_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rs485_tx_scheduler.sv
// RS485 transmit scheduler: pops words from the TX FIFO, starts the transmitter
// and owns the half-duplex driver enable with lead/tail guard times.
module rs485_tx_scheduler
  import rs485_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEAD_CYC    = 4,
  parameter int TAIL_CYC    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rx_busy,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_start,
  input  logic              tx_complete,
  output logic              drv_en,
  output logic              timeout_err,
  output logic [SENT_W-1:0] sent_count,
  output logic              idle
);

  localparam int           TW        = timer_w(LEAD_CYC, TAIL_CYC, TIMEOUT_CYC);
  localparam bit           CFG_OK    = cfg_ok(DATA_W, LEAD_CYC, TAIL_CYC, TIMEOUT_CYC);
  localparam logic [TW-1:0] LEAD_LOAD = TW'(LEAD_CYC - 1);
  localparam logic [TW-1:0] TAIL_LOAD = TW'(TAIL_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC);

  // Handshakes: fifo_rd is a one-cycle pop and fifo_data is captured on the
  // following cycle; tx_start is a one-cycle pulse and the transmitter answers
  // with a one-cycle tx_complete, which is ignored on the tx_start cycle itself.

  rs485_state_e  state, state_next;
  logic          burst, burst_next;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic [TW-1:0] timer_count;
  logic          timer_zero;
  logic          send_first;
  logic          word_done;
  logic          word_timeout;

  rs485_cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // The timer is loaded with TIMEOUT_CYC on SEND entry, so the full value marks the first SEND cycle.
  assign send_first   = (state == ST_SEND) && (timer_count == TMO_LOAD);
  assign word_done    = (state == ST_SEND) && !send_first && tx_complete;
  assign word_timeout = (state == ST_SEND) && !send_first && !tx_complete && timer_zero;

  always_comb begin
    state_next = state;
    burst_next = burst;
    timer_load = 1'b0;
    timer_val  = TMO_LOAD;
    case (state)
      ST_IDLE: begin
        burst_next = 1'b0;
        if (enable && !fifo_empty && !rx_busy) state_next = ST_POP;
      end
      ST_POP: state_next = ST_LOAD;
      ST_LOAD: begin
        timer_load = 1'b1;
        if (burst) begin
          state_next = ST_SEND;
          timer_val  = TMO_LOAD;
        end else begin
          state_next = ST_LEAD;
          timer_val  = LEAD_LOAD;
        end
      end
      ST_LEAD: begin
        if (timer_zero) begin
          state_next = ST_SEND;
          timer_load = 1'b1;
          timer_val  = TMO_LOAD;
        end
      end
      ST_SEND: begin
        if (word_done) begin
          if (enable && !fifo_empty) begin
            burst_next = 1'b1;
            state_next = ST_POP;
          end else begin
            state_next = ST_TAIL;
            timer_load = 1'b1;
            timer_val  = TAIL_LOAD;
          end
        end else if (word_timeout) begin
          state_next = ST_TAIL;
          timer_load = 1'b1;
          timer_val  = TAIL_LOAD;
        end
      end
      ST_TAIL: begin
        if (timer_zero) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      burst      <= 1'b0;
      tx_byte    <= '0;
      sent_count <= '0;
    end else begin
      state <= state_next;
      burst <= burst_next;
      if (state == ST_LOAD) tx_byte <= fifo_data;
      if (word_done) sent_count <= sent_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (CFG_OK);
  end

  assign fifo_rd     = (state == ST_POP);
  assign tx_start    = send_first;
  assign timeout_err = word_timeout;
  assign idle        = (state == ST_IDLE);
  assign drv_en      = (state == ST_LEAD) || (state == ST_SEND) || (state == ST_TAIL) ||
                       (((state == ST_POP) || (state == ST_LOAD)) && burst);

endmodule

// File: tb/tb_rs485_tx_scheduler.sv
// Self-checking bench for rs485_tx_scheduler: a FIFO/transmitter model drives the
// DUT and event cycles are compared with timings computed from the protocol rules.
module tb_rs485_tx_scheduler;

  localparam int DATA_W = 16;
  localparam int LEAD   = 4;
  localparam int TAIL   = 4;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst, enable, rx_busy, fifo_empty, fifo_rd;
  logic              tx_start, tx_complete, drv_en, timeout_err, idle;
  logic [DATA_W-1:0] fifo_data, tx_byte;
  logic [7:0]        sent_count;

  always #5 clk = ~clk;

  rs485_tx_scheduler #(
    .DATA_W(DATA_W), .LEAD_CYC(LEAD), .TAIL_CYC(TAIL), .TIMEOUT_CYC(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_busy(rx_busy), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_complete(tx_complete), .drv_en(drv_en), .timeout_err(timeout_err),
    .sent_count(sent_count), .idle(idle)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int complete_at = -1;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] word_log[$];
  int delay_q[$], model_d[$];
  int rd_log[$], start_log[$], cmpl_log[$], to_log[$], rise_log[$], fall_log[$];
  int exp_rd[$], exp_start[$];
  int exp_fall;
  logic rd_pend = 1'b0;
  logic drv_prev = 1'b0;
  logic [DATA_W-1:0] rd_word;

  // ---------------- clock/cycle driver and environment model ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    fifo_data = rd_pend ? rd_word : DATA_W'($urandom);
    rd_pend = 1'b0;
    tx_complete = (cyc == complete_at);
    if (tx_complete) cmpl_log.push_back(cyc);
    @(negedge clk);
    if (fifo_rd) begin
      rd_log.push_back(cyc);
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL fifo_rd_when_empty cycle=%0d got fifo_rd=1 want 0", cyc);
      end else begin
        rd_word = fifo_q.pop_front();
        rd_pend = 1'b1;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    if (tx_start) begin
      start_log.push_back(cyc);
      word_log.push_back(tx_byte);
      if (delay_q.size() > 0) begin
        int d;
        d = delay_q.pop_front();
        complete_at = (d > 0) ? cyc + d : -1;
      end else begin
        complete_at = -1;
      end
    end
    if (timeout_err) to_log.push_back(cyc);
    if (drv_en && !drv_prev) rise_log.push_back(cyc);
    if (!drv_en && drv_prev) fall_log.push_back(cyc);
    drv_prev = drv_en;
  endtask

  task automatic clear_logs();
    rd_log.delete(); start_log.delete(); cmpl_log.delete(); to_log.delete();
    rise_log.delete(); fall_log.delete(); word_log.delete();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input int d);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    delay_q.push_back(d);
    model_d.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic reset_dut();
    enable = 1'b0; rx_busy = 1'b0; rst = 1'b1;
    fifo_q.delete(); exp_q.delete(); delay_q.delete(); model_d.delete();
    fifo_empty = 1'b1; complete_at = -1;
    step(); step();
    rst = 1'b0;
    clear_logs();
    drv_prev = drv_en;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference timing: burst starting condition in cycle n, all words queued up front.
  task automatic predict(input int n);
    int s, r, m;
    exp_rd.delete(); exp_start.delete();
    r = n + 1; s = n + 3 + LEAD; m = s;
    foreach (model_d[i]) begin
      exp_rd.push_back(r);
      exp_start.push_back(s);
      m = s + model_d[i];
      r = m + 1;
      s = m + 3;
    end
    exp_fall = m + 1 + TAIL;
    model_d.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got %b want 0", fifo_rd); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (drv_en !== 1'b0) begin failures++; $display("FAIL reset_drv_en got %b want 0", drv_en); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    checks++; if (tx_byte !== '0) begin failures++; $display("FAIL reset_tx_byte got %h want 0", tx_byte); end
    checks++; if (sent_count !== 8'd0) begin failures++; $display("FAIL reset_sent_count got %0d want 0", sent_count); end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int n;
    bit ok;
    reset_dut();
    push_word(16'hA55A, 50);
    enable = 1'b1; n = cyc; clear_logs();
    step();
    checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL single_rd_n1 got %b want 1", fifo_rd); end
    step(); step();
    checks++; if (tx_byte !== 16'hA55A) begin failures++; $display("FAIL single_tx_byte got %h want a55a", tx_byte); end
    checks++; if (drv_en !== 1'b1) begin failures++; $display("FAIL single_drv_rise got %b want 1", drv_en); end
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle_timeout got busy want idle"); end
    checks++; if (at(start_log, 0) != n + 7) begin failures++; $display("FAIL single_tx_start got %0d want %0d", at(start_log, 0), n + 7); end
    checks++; if (at(fall_log, 0) != n + 57 + 1 + TAIL) begin failures++; $display("FAIL single_drv_fall got %0d want %0d", at(fall_log, 0), n + 58 + TAIL); end
    checks++; if (sent_count !== 8'd1) begin failures++; $display("FAIL single_sent got %0d want 1", sent_count); end
  endtask

  task automatic test_burst();
    int n, nw;
    bit ok;
    logic [7:0] exp_sent;
    reset_dut();
    exp_sent = 8'd0;
    for (int it = 0; it < 6; it++) begin
      nw = (it == 0) ? 3 : int'($urandom_range(1, 4));
      for (int i = 0; i < nw; i++)
        push_word((it == 0) ? DATA_W'(i + 1) : DATA_W'($urandom), int'($urandom_range(1, 40)));
      repeat ($urandom_range(0, 5)) step();
      enable = 1'b1; n = cyc; clear_logs();
      predict(n);
      exp_sent = exp_sent + 8'(nw);
      wait_idle(1000, ok);
      enable = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL burst_idle_timeout it=%0d", it); end
      checks++; if (rd_log.size() != nw) begin failures++; $display("FAIL burst_rd_count it=%0d got %0d want %0d", it, rd_log.size(), nw); end
      for (int i = 0; i < nw; i++) begin
        checks++; if (at(rd_log, i) != exp_rd[i]) begin failures++; $display("FAIL burst_rd_cycle it=%0d w=%0d got %0d want %0d", it, i, at(rd_log, i), exp_rd[i]); end
        checks++; if (at(start_log, i) != exp_start[i]) begin failures++; $display("FAIL burst_start_cycle it=%0d w=%0d got %0d want %0d", it, i, at(start_log, i), exp_start[i]); end
        checks++; if (i >= word_log.size() || word_log[i] !== exp_q[0]) begin failures++; $display("FAIL burst_word it=%0d w=%0d want %h", it, i, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      checks++; if (rise_log.size() != 1 || rise_log[0] != n + 3) begin failures++; $display("FAIL burst_single_lead it=%0d got rises=%0d first=%0d want 1 at %0d", it, rise_log.size(), at(rise_log, 0), n + 3); end
      checks++; if (fall_log.size() != 1 || fall_log[0] != exp_fall) begin failures++; $display("FAIL burst_drv_fall it=%0d got falls=%0d at %0d want 1 at %0d", it, fall_log.size(), at(fall_log, 0), exp_fall); end
      checks++; if (sent_count !== exp_sent) begin failures++; $display("FAIL burst_sent it=%0d got %0d want %0d", it, sent_count, exp_sent); end
    end
  endtask

  task automatic test_rx_busy();
    int n;
    bit ok;
    reset_dut();
    push_word(16'h3C3C, int'($urandom_range(1, 30)));
    enable = 1'b1; rx_busy = 1'b1; clear_logs();
    repeat (20) step();
    checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL rxbusy_no_pop got %0d pops want 0", rd_log.size()); end
    checks++; if (rise_log.size() != 0 || drv_en !== 1'b0) begin failures++; $display("FAIL rxbusy_drv_en got rises=%0d want 0", rise_log.size()); end
    rx_busy = 1'b0; n = cyc;
    predict(n);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rxbusy_idle_timeout"); end
    checks++; if (at(rd_log, 0) != exp_rd[0]) begin failures++; $display("FAIL rxbusy_rd got %0d want %0d", at(rd_log, 0), exp_rd[0]); end
    checks++; if (at(start_log, 0) != exp_start[0]) begin failures++; $display("FAIL rxbusy_start got %0d want %0d", at(start_log, 0), exp_start[0]); end
  endtask

  task automatic test_timeout();
    int n, s;
    bit ok;
    reset_dut();
    push_word(16'h1234, 0);
    enable = 1'b1; n = cyc; s = n + 3 + LEAD; clear_logs();
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_idle_timeout"); end
    checks++; if (to_log.size() != 1 || to_log[0] != s + TMO) begin failures++; $display("FAIL timeout_pulse got n=%0d at %0d want 1 at %0d", to_log.size(), at(to_log, 0), s + TMO); end
    checks++; if (sent_count !== 8'd0) begin failures++; $display("FAIL timeout_sent got %0d want 0", sent_count); end
    checks++; if (at(fall_log, 0) != s + TMO + 1 + TAIL) begin failures++; $display("FAIL timeout_drv_fall got %0d want %0d", at(fall_log, 0), s + TMO + 1 + TAIL); end
    // completion one cycle before the deadline is accepted
    push_word(16'h5678, TMO - 1);
    n = cyc; s = n + 3 + LEAD; clear_logs();
    wait_idle(400, ok);
    checks++; if (to_log.size() != 0 || sent_count !== 8'd1) begin failures++; $display("FAIL timeout_edge got pulses=%0d sent=%0d want 0/1", to_log.size(), sent_count); end
    checks++; if (at(fall_log, 0) != s + TMO + TAIL) begin failures++; $display("FAIL timeout_edge_fall got %0d want %0d", at(fall_log, 0), s + TMO + TAIL); end
    // a completion on the tx_start cycle is ignored
    push_word(16'h9ABC, 10);
    n = cyc; s = n + 3 + LEAD; complete_at = s; clear_logs();
    wait_idle(400, ok);
    enable = 1'b0;
    checks++; if (sent_count !== 8'd2) begin failures++; $display("FAIL same_cycle_cmpl_sent got %0d want 2", sent_count); end
    checks++; if (at(fall_log, 0) != s + 10 + 1 + TAIL) begin failures++; $display("FAIL same_cycle_cmpl_fall got %0d want %0d", at(fall_log, 0), s + 11 + TAIL); end
    model_d.delete();
  endtask

  task automatic test_enable_drop();
    int n, s;
    bit ok;
    reset_dut();
    push_word(16'h0A0A, 30);
    push_word(16'h0B0B, 30);
    enable = 1'b1; n = cyc; s = n + 3 + LEAD; clear_logs();
    while (cyc < s + 5) step();
    enable = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL endrop_idle_timeout"); end
    checks++; if (rd_log.size() != 1 || fifo_q.size() != 1) begin failures++; $display("FAIL endrop_pops got %0d left=%0d want 1/1", rd_log.size(), fifo_q.size()); end
    checks++; if (sent_count !== 8'd1) begin failures++; $display("FAIL endrop_sent got %0d want 1", sent_count); end
    checks++; if (fall_log.size() != 1 || fall_log[0] != s + 30 + 1 + TAIL) begin failures++; $display("FAIL endrop_drv_fall got %0d at %0d want 1 at %0d", fall_log.size(), at(fall_log, 0), s + 31 + TAIL); end
    model_d.delete();
  endtask

  task automatic test_reset_in_lead();
    int n;
    bit ok;
    reset_dut();
    push_word(16'h1111, 5);
    enable = 1'b1;
    wait_idle(200, ok);
    push_word(16'hBEEF, 5);
    n = cyc;
    while (cyc < n + 4) step();
    checks++; if (tx_byte !== 16'hBEEF || sent_count !== 8'd1) begin failures++; $display("FAIL lead_pre got %h/%0d want beef/1", tx_byte, sent_count); end
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    checks++; if (idle !== 1'b1 || drv_en !== 1'b0) begin failures++; $display("FAIL lead_reset_idle got idle=%b drv_en=%b want 1/0", idle, drv_en); end
    checks++; if (tx_byte !== '0 || sent_count !== 8'd0) begin failures++; $display("FAIL lead_reset_regs got %h/%0d want 0/0", tx_byte, sent_count); end
    checks++; if (fifo_rd !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL lead_reset_strobes got %b%b%b want 000", fifo_rd, tx_start, timeout_err); end
    model_d.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    reset_dut();
    for (int i = 0; i < 256; i++) push_word(DATA_W'($urandom), 1);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (cmpl_log.size() == 255) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    checks++; if (!ok || sent_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got %0d want 255", sent_count); end
    wait_idle(100, ok);
    enable = 1'b0;
    checks++; if (!ok || sent_count !== 8'd0 || cmpl_log.size() != 256) begin failures++; $display("FAIL wrap_0 got %0d after %0d completions want 0 after 256", sent_count, cmpl_log.size()); end
    model_d.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx_busy = 1'b0; fifo_empty = 1'b1;
    tx_complete = 1'b0; fifo_data = '0;
    test_reset();
    test_single_word();
    test_burst();
    test_rx_busy();
    test_timeout();
    test_enable_drop();
    test_reset_in_lead();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
